icache_refill_ctrl: RTL and testbench

Sequences instruction-cache miss handling in the fetch unit. On an icache lookup miss it issues one block-aligned DRAM read, waits for the response, writes the returned block into the icache through its write port, and holds the PC while the refill is outstanding. It sits between the IFU's PC/icache datapath and the DRAM interface, and handles recovery-PC flushes that arrive mid-refill.

---
 rtl/icache_pkg.sv | 18 +
 rtl/icache_refill_ctrl_sat_counter.sv | 23 ++
 rtl/icache_refill_ctrl.sv | 166 ++++++++++++++++
 tb/tb_icache_refill_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared fetch-unit constants and types for the icache refill path.
package icache_pkg;

    localparam int ADDR_WIDTH             = 32;
    localparam int ICACHE_DATA_BLOCK_SIZE = 64;
    localparam int BLOCK_OFFSET_BITS      = 3;

    typedef logic [ICACHE_DATA_BLOCK_SIZE-1:0] block_t;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        FILL,
        DRAIN
    } refill_state_t;

endpackage

// File: rtl/icache_refill_ctrl_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/icache_refill_ctrl.sv
// Icache miss refill sequencer: one block read per miss, flush-aware drain of stale responses.
// Optional miss counter enabled by defining ICACHE_MISS_PERF_EN.
module icache_refill_ctrl
    import icache_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int BLOCK_SIZE = 64
) (
    input  logic                  clk,
    input  logic                  rst_aL,
    input  logic                  icache_miss,
    input  logic [ADDR_WIDTH-1:0] miss_PC,
    input  logic                  recovery_PC_valid,
    output logic                  dram_req_valid,
    input  logic                  dram_req_ready,
    output logic [ADDR_WIDTH-1:0] dram_req_addr,
    input  logic [BLOCK_SIZE-1:0] dram_response,
    input  logic                  dram_response_valid,
    output logic                  icache_we,
    output logic                  icache_csb0,
    output logic [ADDR_WIDTH-1:0] icache_waddr,
    output logic [BLOCK_SIZE-1:0] icache_wdata,
    output logic                  ifu_stall,
    output logic [31:0]           miss_count
);

    localparam int OFF = BLOCK_OFFSET_BITS;

    function automatic logic [ADDR_WIDTH-1:0] align(input logic [ADDR_WIDTH-1:0] a);
        align          = a;
        align[OFF-1:0] = '0;
    endfunction

    refill_state_t         state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  pending_q;
    logic                  req_valid_q;
    logic [ADDR_WIDTH-1:0] req_addr_q;
    logic                  we_q;
    logic                  csb_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [BLOCK_SIZE-1:0] wdata_q;
    logic                  stall_q;

    logic [ADDR_WIDTH-1:0] miss_blk_d;
    logic [ADDR_WIDTH-1:0] drain_addr_d;
    logic                  pending_d;

    assign miss_blk_d = align(miss_PC);

    // While draining, a flush cancels any queued miss; otherwise the newest miss wins.
    always_comb begin
        pending_d    = pending_q;
        drain_addr_d = addr_q;
        if (recovery_PC_valid) begin
            pending_d = 1'b0;
        end else if (icache_miss) begin
            pending_d    = 1'b1;
            drain_addr_d = miss_blk_d;
        end
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            pending_q   <= 1'b0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            we_q        <= 1'b0;
            csb_q       <= 1'b1;
            waddr_q     <= '0;
            wdata_q     <= '0;
            stall_q     <= 1'b0;
        end else begin
            we_q  <= 1'b0;
            csb_q <= 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (icache_miss && !recovery_PC_valid) begin
                        addr_q      <= miss_blk_d;
                        req_addr_q  <= miss_blk_d;
                        req_valid_q <= 1'b1;
                        stall_q     <= 1'b1;
                        state_q     <= REQ;
                    end
                end
                REQ: begin
                    if (dram_req_ready) begin
                        req_valid_q <= 1'b0;
                        if (recovery_PC_valid) begin
                            stall_q   <= 1'b0;
                            pending_q <= 1'b0;
                            state_q   <= DRAIN;
                        end else begin
                            state_q <= WAIT;
                        end
                    end else if (recovery_PC_valid) begin
                        req_valid_q <= 1'b0;
                        stall_q     <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                WAIT: begin
                    if (dram_response_valid) begin
                        wdata_q <= dram_response;
                        waddr_q <= addr_q;
                        we_q    <= 1'b1;
                        csb_q   <= 1'b0;
                        state_q <= FILL;
                    end else if (recovery_PC_valid) begin
                        stall_q   <= 1'b0;
                        pending_q <= 1'b0;
                        state_q   <= DRAIN;
                    end
                end
                // The write is for addr_q and stays valid even if a flush arrives now.
                FILL: begin
                    stall_q <= 1'b0;
                    state_q <= IDLE;
                end
                DRAIN: begin
                    addr_q    <= drain_addr_d;
                    pending_q <= pending_d;
                    if (dram_response_valid) begin
                        pending_q <= 1'b0;
                        if (pending_d) begin
                            req_addr_q  <= drain_addr_d;
                            req_valid_q <= 1'b1;
                            stall_q     <= 1'b1;
                            state_q     <= REQ;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dram_req_valid = req_valid_q;
    assign dram_req_addr  = req_addr_q;
    assign icache_we      = we_q;
    assign icache_csb0    = csb_q;
    assign icache_waddr   = waddr_q;
    assign icache_wdata   = wdata_q;
    assign ifu_stall      = stall_q;

`ifdef ICACHE_MISS_PERF_EN
    logic req_fire;
    assign req_fire = (state_q == REQ) && dram_req_ready;

    sat_counter #(
        .WIDTH(32)
    ) u_miss_ctr (
        .clk_i  (clk),
        .rst_ni (rst_aL),
        .inc_i  (req_fire),
        .count_o(miss_count)
    );
`else
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Scoreboard bench for icache_refill_ctrl: expected DRAM requests and icache writes are queued by the driver, popped by a monitor.
module tb_icache_refill_ctrl;

    logic        clk = 1'b0;
    logic        rst_aL;
    logic        icache_miss;
    logic [31:0] miss_PC;
    logic        recovery_PC_valid;
    logic        dram_req_valid;
    logic        dram_req_ready;
    logic [31:0] dram_req_addr;
    logic [63:0] dram_response;
    logic        dram_response_valid;
    logic        icache_we;
    logic        icache_csb0;
    logic [31:0] icache_waddr;
    logic [63:0] icache_wdata;
    logic        ifu_stall;
    logic [31:0] miss_count;

    icache_refill_ctrl #(.ADDR_WIDTH(32), .BLOCK_SIZE(64)) dut (
        .clk                (clk),
        .rst_aL             (rst_aL),
        .icache_miss        (icache_miss),
        .miss_PC            (miss_PC),
        .recovery_PC_valid  (recovery_PC_valid),
        .dram_req_valid     (dram_req_valid),
        .dram_req_ready     (dram_req_ready),
        .dram_req_addr      (dram_req_addr),
        .dram_response      (dram_response),
        .dram_response_valid(dram_response_valid),
        .icache_we          (icache_we),
        .icache_csb0        (icache_csb0),
        .icache_waddr       (icache_waddr),
        .icache_wdata       (icache_wdata),
        .ifu_stall          (ifu_stall),
        .miss_count         (miss_count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_req_q[$];
    logic [95:0] exp_wr_q[$];
    int unsigned exp_count = 0;
    logic [95:0] wr_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_mc();
`ifdef ICACHE_MISS_PERF_EN
        return exp_count;
`else
        return 32'd0;
`endif
    endfunction

    // Monitor: every accepted request and every icache write must match the head of its queue.
    always @(negedge clk) begin
        if (rst_aL === 1'b1) begin
            if (dram_req_valid && dram_req_ready) begin
                if (exp_req_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_req: got %h expected none", dram_req_addr);
                end else begin
                    chk("req_addr_sb", dram_req_addr, exp_req_q.pop_front());
                end
            end
            if (icache_we) begin
                if (exp_wr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: got %h expected none", icache_waddr);
                end else begin
                    wr_e = exp_wr_q.pop_front();
                    chk("wr_addr", icache_waddr, wr_e[95:64]);
                    chk("wr_data", icache_wdata, wr_e[63:0]);
                    chk("wr_csb", icache_csb0, 0);
                end
            end else if (icache_csb0 !== 1'b1) begin
                checks++; errors++;
                $display("FAIL csb_idle: got %b expected 1", icache_csb0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_miss(input logic [31:0] pc);
        icache_miss = 1'b1;
        miss_PC     = pc;
        tick();
        icache_miss = 1'b0;
        miss_PC     = $urandom;
    endtask

    task automatic handshake(input logic [31:0] blk, input int rdly, input logic flush);
        for (int i = 0; i < rdly; i++) begin
            chk("req_valid_held", dram_req_valid, 1);
            chk("req_addr_held", dram_req_addr, blk);
            chk("stall_req", ifu_stall, 1);
            tick();
        end
        chk("req_valid", dram_req_valid, 1);
        chk("req_addr", dram_req_addr, blk);
        exp_req_q.push_back(blk);
        exp_count++;
        dram_req_ready    = 1'b1;
        recovery_PC_valid = flush;
        tick();
        dram_req_ready    = 1'b0;
        recovery_PC_valid = 1'b0;
        chk("req_valid_drop", dram_req_valid, 0);
    endtask

    task automatic respond(input logic [63:0] d);
        dram_response_valid = 1'b1;
        dram_response       = d;
        tick();
        dram_response_valid = 1'b0;
        dram_response       = {$urandom, $urandom};
    endtask

    // Runs a refill from the REQ state through FILL back to IDLE.
    task automatic complete(input logic [31:0] blk, input int rdly, input int lat,
                            input logic [63:0] data, input logic flush_fill);
        handshake(blk, rdly, 1'b0);
        for (int i = 0; i < lat; i++) begin
            chk("stall_wait", ifu_stall, 1);
            tick();
        end
        exp_wr_q.push_back({blk, data});
        respond(data);
        chk("stall_fill", ifu_stall, 1);
        chk("we_fill", icache_we, 1);
        recovery_PC_valid = flush_fill;
        tick();
        recovery_PC_valid = 1'b0;
        chk("stall_idle", ifu_stall, 0);
        chk("req_idle", dram_req_valid, 0);
        chk("miss_count", miss_count, exp_mc());
    endtask

    task automatic refill(input logic [31:0] pc, input int rdly, input int lat,
                          input logic [63:0] data, input logic flush_fill);
        chk("stall_pre", ifu_stall, 0);
        issue_miss(pc);
        chk("stall_n1", ifu_stall, 1);
        complete(pc & ~32'h7, rdly, lat, data, flush_fill);
    endtask

    task automatic flush_wait(input logic [31:0] pc, input int rdly, input int lat,
                              input logic flush_in_hs, input logic new_miss,
                              input logic kill, input logic [31:0] pc2);
        issue_miss(pc);
        handshake(pc & ~32'h7, rdly, flush_in_hs);
        if (!flush_in_hs) begin
            for (int i = 0; i < lat; i++) begin
                chk("stall_wait", ifu_stall, 1);
                tick();
            end
            recovery_PC_valid = 1'b1;
            tick();
            recovery_PC_valid = 1'b0;
        end
        chk("stall_drain", ifu_stall, 0);
        chk("req_drain", dram_req_valid, 0);
        if (new_miss) begin
            issue_miss(pc2);
            chk("stall_drain_miss", ifu_stall, 0);
            if (kill) begin
                recovery_PC_valid = 1'b1;
                tick();
                recovery_PC_valid = 1'b0;
                chk("stall_drain_kill", ifu_stall, 0);
            end
        end
        respond(64'hDEADBEEF_DEADBEEF);
        chk("we_discard", icache_we, 0);
        if (new_miss && !kill) begin
            chk("stall_rereq", ifu_stall, 1);
            complete(pc2 & ~32'h7, $urandom_range(0, 2), $urandom_range(0, 4),
                     {$urandom, $urandom}, 1'b0);
        end else begin
            chk("stall_after_drain", ifu_stall, 0);
            chk("req_after_drain", dram_req_valid, 0);
            chk("miss_count", miss_count, exp_mc());
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, dram_req_valid, 0);
        chk({tag, "_req_addr"}, dram_req_addr, 0);
        chk({tag, "_we"}, icache_we, 0);
        chk({tag, "_csb"}, icache_csb0, 1);
        chk({tag, "_waddr"}, icache_waddr, 0);
        chk({tag, "_wdata"}, icache_wdata, 0);
        chk({tag, "_stall"}, ifu_stall, 0);
        chk({tag, "_count"}, miss_count, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc;
        int          sel;
        rst_aL              = 1'b1;
        icache_miss         = 1'b0;
        miss_PC             = '0;
        recovery_PC_valid   = 1'b0;
        dram_req_ready      = 1'b0;
        dram_response       = '0;
        dram_response_valid = 1'b0;
        #2 rst_aL = 1'b0;
        #1 check_reset_outputs("reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst_aL = 1'b1;
        tick();

        refill(32'h0001018c, 0, 5, 64'h00112e23_fe010113, 1'b0);
        refill(32'h00020004, 3, 2, {$urandom, $urandom}, 1'b0);
        flush_wait(32'h00030010, 0, 2, 1'b0, 1'b0, 1'b0, 32'h0);
        flush_wait(32'h00030010, 1, 1, 1'b0, 1'b1, 1'b0, 32'h000101c0);

        icache_miss = 1'b1; miss_PC = 32'h00040000; recovery_PC_valid = 1'b1;
        tick();
        icache_miss = 1'b0; recovery_PC_valid = 1'b0;
        chk("idle_flush_req", dram_req_valid, 0);
        chk("idle_flush_stall", ifu_stall, 0);

        refill(32'h00050028, 0, 1, {$urandom, $urandom}, 1'b1);

        // Asynchronous reset while a response is outstanding.
        issue_miss(32'h00060008);
        handshake(32'h00060008, 0, 1'b0);
        tick();
        rst_aL = 1'b0;
        #1 check_reset_outputs("midreset");
        exp_count = 0;
        @(posedge clk);
        #1 rst_aL = 1'b1;
        tick();
        refill(32'h00070000, 0, 0, {$urandom, $urandom}, 1'b0);
        refill(32'h00070040, 1, 3, {$urandom, $urandom}, 1'b0);

        for (int it = 0; it < 40; it++) begin
            sel = $urandom_range(0, 6);
            pc  = $urandom;
            case (sel)
                0, 1: refill(pc, $urandom_range(0, 3), $urandom_range(0, 6), {$urandom, $urandom}, 1'b0);
                2: flush_wait(pc, $urandom_range(0, 2), $urandom_range(0, 3), 1'b0,
                              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
                3: flush_wait(pc, $urandom_range(0, 2), 0, 1'b1,
                              1'($urandom_range(0, 1)), 1'b0, $urandom);
                4: begin
                    issue_miss(pc);
                    recovery_PC_valid = 1'b1;
                    tick();
                    recovery_PC_valid = 1'b0;
                    chk("req_flush_valid", dram_req_valid, 0);
                    chk("req_flush_stall", ifu_stall, 0);
                end
                5: refill(pc, $urandom_range(0, 2), $urandom_range(0, 4), {$urandom, $urandom}, 1'b1);
                default: begin
                    icache_miss = 1'b1; miss_PC = pc; recovery_PC_valid = 1'b1;
                    tick();
                    icache_miss = 1'b0; recovery_PC_valid = 1'b0;
                    chk("idle_flush_req", dram_req_valid, 0);
                    chk("idle_flush_stall", ifu_stall, 0);
                end
            endcase
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                chk("gap_stall", ifu_stall, 0);
                tick();
            end
        end

        tick();
        chk("req_queue_empty", exp_req_q.size(), 0);
        chk("wr_queue_empty", exp_wr_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
